// File: rtl/router_pkg.sv
// router_pkg: direction encodings and routing helpers shared by the router input port
package router_pkg;
  localparam int NUM_DIR = 5;
  localparam int ADDR_MAX = 32;
  localparam int FLIT_MAX = 512;
  typedef logic [NUM_DIR-1:0] dirT;
  localparam dirT DIR_L = 5'b10000;
  localparam dirT DIR_R = 5'b01000;
  localparam dirT DIR_U = 5'b00100;
  localparam dirT DIR_D = 5'b00010;
  localparam dirT DIR_PE = 5'b00001;
  function automatic logic [ADDR_MAX-1:0] addrField(input logic [FLIT_MAX-1:0] flit, input int lsb, input int w);
    return ADDR_MAX'(flit >> lsb) & ({ADDR_MAX{1'b1}} >> (ADDR_MAX - w));
  endfunction
  function automatic dirT xyRoute(input logic [ADDR_MAX-1:0] dstX, input logic [ADDR_MAX-1:0] dstY,
                                  input logic [ADDR_MAX-1:0] curX, input logic [ADDR_MAX-1:0] curY);
    return dstX > curX ? DIR_R : dstX < curX ? DIR_L : dstY > curY ? DIR_U : dstY < curY ? DIR_D : DIR_PE;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered count and combinational read of the oldest entry
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic doPush, doPop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign doPush = push && !full;
  assign doPop = pop && !empty;
  assign dout = mem[rdPtr];
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop) rdPtr <= rdPtr + 1'b1;
      count <= count + CW'(doPush) - CW'(doPop);
    end
  end
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end
endmodule

// File: rtl/router_input_port.sv
// router_input_port: buffered mesh router input with XY/minimal-adaptive routing and a registered head slot
module router_input_port
  import router_pkg::*;
#(
  parameter int         DATA_WIDTH   = 64,
  parameter int         BUFFER_DEPTH = 4,
  parameter int         ADDR_W       = 8,
  parameter int         CUR_X        = 0,
  parameter int         CUR_Y        = 0,
  parameter logic [4:0] DIRECTION    = 5'b00001,
  parameter bit         ADAPTIVE     = 1'b0,
  parameter int         CNT_W        = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              si,
  input  logic [DATA_WIDTH-1:0]             datai,
  output logic                              ri,
  output logic [NUM_DIR-1:0]                req,
  output logic [DATA_WIDTH-1:0]             datao,
  input  logic [NUM_DIR-1:0]                gnt,
  input  logic [NUM_DIR-1:0]                out_busy,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]                  pkt_cnt,
  output logic                              err_gnt
);
  localparam int OCC_W = $clog2(BUFFER_DEPTH + 1);
  localparam logic [ADDR_MAX-1:0] CX = ADDR_MAX'(CUR_X);
  localparam logic [ADDR_MAX-1:0] CY = ADDR_MAX'(CUR_Y);
  logic [DATA_WIDTH-1:0] fifoDout, headData;
  logic fifoFull, fifoEmpty;
  logic [OCC_W-1:0] fifoCount;
  logic [ADDR_MAX-1:0] dstX, dstY;
  dirT headRoute, xyDir, yDir, loadRoute;
  logic consume, load, badGnt, swapToY;
  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(BUFFER_DEPTH)) fifo (
    .clk(clk), .rst(rst), .push(si && ri), .pop(load), .din(datai),
    .dout(fifoDout), .full(fifoFull), .empty(fifoEmpty), .count(fifoCount)
  );
  assign ri = !fifoFull;
  assign req = headRoute;
  assign datao = headData;
  assign occupancy = fifoCount + OCC_W'(|headRoute);
  // an empty head slot is encoded as an all-zero route
  assign consume = |headRoute && gnt == headRoute;
  assign load = !fifoEmpty && (headRoute == '0 || consume);
  assign badGnt = |(gnt & ~headRoute);
  assign dstX = addrField(FLIT_MAX'(fifoDout), DATA_WIDTH - ADDR_W, ADDR_W);
  assign dstY = addrField(FLIT_MAX'(fifoDout), DATA_WIDTH - 2 * ADDR_W, ADDR_W);
  assign xyDir = xyRoute(dstX, dstY, CX, CY);
  assign yDir = dstY > CY ? DIR_U : DIR_D;
  // divert a busy X hop into Y only when that is still minimal and does not send the flit back upstream
  assign swapToY = ADAPTIVE && (xyDir == DIR_R || xyDir == DIR_L) && |(xyDir & out_busy)
                   && dstY != CY && yDir != DIRECTION;
  assign loadRoute = swapToY ? yDir : xyDir;
  always_ff @(posedge clk) begin
    if (!rst) begin
      headData <= '0;
      headRoute <= '0;
      pkt_cnt <= '0;
      err_gnt <= 1'b0;
    end else begin
      if (load) begin
        headData <= fifoDout;
        headRoute <= loadRoute;
      end else if (consume) begin
        headRoute <= '0;
      end
      if (consume) pkt_cnt <= pkt_cnt + 1'b1;
      if (badGnt) err_gnt <= 1'b1;
    end
  end
endmodule

// File: tb/tb_router_input_port.sv
// tb_router_input_port: randomized scoreboard bench against a queue-level reference of the input port
module tb_router_input_port;
  localparam int D = 4;
  logic clk = 1'b0, rst = 1'b0, si = 1'b0;
  logic [63:0] datai = '0, datao;
  logic ri, errGnt;
  logic [4:0] req, gnt = '0, outBusy = '0;
  logic [2:0] occupancy;
  logic [15:0] pktCnt;
  int errors = 0, checks = 0;
  logic [63:0] fifoQ[$], expQ[$];
  bit headFull = 0, err = 0, grantOn = 0;
  logic [4:0] headRoute = '0;
  int pkt = 0;

  always #5 clk = ~clk;

  router_input_port #(
    .DATA_WIDTH(64), .BUFFER_DEPTH(D), .ADDR_W(8), .CUR_X(2), .CUR_Y(2),
    .DIRECTION(5'b00001), .ADAPTIVE(1'b1), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .si(si), .datai(datai), .ri(ri), .req(req), .datao(datao),
    .gnt(gnt), .out_busy(outBusy), .occupancy(occupancy), .pkt_cnt(pktCnt), .err_gnt(errGnt)
  );

  function automatic logic [4:0] refRoute(input logic [63:0] f, input logic [4:0] busy);
    int dx, dy;
    logic [4:0] r, y;
    dx = int'(f[63:56]);
    dy = int'(f[55:48]);
    if (dx > 2) r = 5'b01000;
    else if (dx < 2) r = 5'b10000;
    else if (dy > 2) r = 5'b00100;
    else if (dy < 2) r = 5'b00010;
    else r = 5'b00001;
    y = dy > 2 ? 5'b00100 : 5'b00010;
    if ((r == 5'b01000 || r == 5'b10000) && (busy & r) != 0 && dy != 2 && y != 5'b00001) r = y;
    return r;
  endfunction

  function automatic logic [63:0] mk(input int x, input int y);
    return {8'(x), 8'(y), 16'($urandom), 32'($urandom)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [4:0] curReq;
    bit consume, load, acc;
    curReq = headFull ? headRoute : 5'b0;
    chk("ri", 64'(ri), 64'(fifoQ.size() < D));
    chk("occupancy", 64'(occupancy), 64'(fifoQ.size() + int'(headFull)));
    chk("req", 64'(req), 64'(curReq));
    chk("pkt_cnt", 64'(pktCnt), 64'(16'(pkt)));
    chk("err_gnt", 64'(errGnt), 64'(err));
    consume = headFull && gnt == headRoute;
    if (rst && consume) begin
      if (expQ.size() == 0) chk("sb_underflow", 64'(1), 64'(0));
      else chk("datao", datao, expQ.pop_front());
    end
    if (!rst) begin
      fifoQ.delete();
      expQ.delete();
      headFull = 0;
      headRoute = '0;
      pkt = 0;
      err = 0;
    end else begin
      acc = si && fifoQ.size() < D;
      load = fifoQ.size() > 0 && (!headFull || consume);
      if ((gnt & ~curReq) != 0) err = 1;
      if (consume) begin
        pkt++;
        headFull = 0;
      end
      if (load) begin
        headRoute = refRoute(fifoQ.pop_front(), outBusy);
        headFull = 1;
      end
      if (acc) fifoQ.push_back(datai);
    end
  end

  task automatic step(input bit s, input logic [63:0] f);
    @(posedge clk);
    #1;
    si = s;
    datai = f;
    if (s && rst && fifoQ.size() < D) expQ.push_back(f);
    gnt = (grantOn && headFull) ? headRoute : 5'b0;
  endtask

  initial begin
    repeat (2) step(0, '0);
    rst = 1'b1;
    step(0, '0);
    chk("rst_ri", 64'(ri), 64'(1));
    chk("rst_occ", 64'(occupancy), 64'(0));
    chk("rst_pkt", 64'(pktCnt), 64'(0));
    grantOn = 1;
    step(1, mk(3, 2));
    step(1, mk(1, 0));
    step(1, mk(2, 5));
    step(1, mk(2, 0));
    step(1, mk(2, 2));
    repeat (8) step(0, '0);
    chk("xy_pkt", 64'(pktCnt), 64'(5));
    grantOn = 0;
    repeat (6) step(1, mk(3, 2));
    step(0, '0);
    chk("bp_occ", 64'(occupancy), 64'(5));
    chk("bp_ri", 64'(ri), 64'(0));
    grantOn = 1;
    step(0, '0);
    grantOn = 0;
    step(0, '0);
    chk("bp_ri_rise", 64'(ri), 64'(1));
    grantOn = 1;
    repeat (8) step(0, '0);
    chk("bp_pkt", 64'(pktCnt), 64'(10));
    repeat (8) step(1, mk(3, 2));
    repeat (4) step(0, '0);
    chk("thr_pkt", 64'(pktCnt), 64'(18));
    grantOn = 0;
    outBusy = 5'b01000;
    step(1, mk(4, 5));
    repeat (2) step(0, '0);
    outBusy = 5'b00000;
    step(0, '0);
    chk("adapt_y", 64'(req), 64'(5'b00100));
    grantOn = 1;
    repeat (2) step(0, '0);
    grantOn = 0;
    step(1, mk(4, 5));
    repeat (2) step(0, '0);
    outBusy = 5'b01000;
    step(0, '0);
    chk("adapt_x", 64'(req), 64'(5'b01000));
    grantOn = 1;
    repeat (3) step(0, '0);
    chk("adapt_pkt", 64'(pktCnt), 64'(20));
    repeat (400) begin
      grantOn = ($urandom % 2) == 1;
      outBusy = 5'($urandom);
      step(($urandom % 2) == 1, mk(int'($urandom % 5), int'($urandom % 5)));
    end
    grantOn = 1;
    outBusy = '0;
    repeat (12) step(0, '0);
    chk("drain_occ", 64'(occupancy), 64'(0));
    grantOn = 0;
    step(1, mk(3, 2));
    repeat (2) step(0, '0);
    chk("err_pre", 64'(errGnt), 64'(0));
    gnt = 5'b10000;
    step(0, '0);
    chk("err_set", 64'(errGnt), 64'(1));
    chk("err_req_hold", 64'(req), 64'(5'b01000));
    gnt = 5'b11000;
    step(0, '0);
    chk("multi_no_pop", 64'(occupancy), 64'(1));
    repeat (3) step(1, mk(1, 1));
    step(0, '0);
    chk("err_sticky", 64'(errGnt), 64'(1));
    chk("pre_rst_occ", 64'(occupancy), 64'(4));
    rst = 1'b0;
    step(0, '0);
    rst = 1'b1;
    chk("mid_rst_occ", 64'(occupancy), 64'(0));
    chk("mid_rst_req", 64'(req), 64'(0));
    chk("mid_rst_err", 64'(errGnt), 64'(0));
    repeat (3) step(0, '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
